// File: rtl/cpc_fec_pkg.sv
// Shared types for the streaming cross-parity FEC corrector.
// Index fields are sized for up to 64 rows or columns.
package cpc_fec_pkg;

    localparam int IDX_W = 6;
    localparam int VEC_W = 64;

    typedef enum logic [1:0] {
        COLLECT,
        DECIDE,
        DRAIN
    } state_e;

    typedef struct packed {
        logic             det;
        logic             corr;
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
    } status_t;

    typedef struct packed {
        logic             is_onehot;
        logic [IDX_W-1:0] index;
    } onehot_t;

    function automatic onehot_t onehot_idx(input logic [VEC_W-1:0] vec);
        onehot_t     res;
        int unsigned n;
        res = '0;
        n   = 0;
        for (int i = 0; i < VEC_W; i++) begin
            if (vec[i]) begin
                n++;
                res.index = IDX_W'(i);
            end
        end
        res.is_onehot = (n == 1);
        return res;
    endfunction

endpackage

// File: rtl/cpc_fec_locator.sv
// Combinational syndrome classifier: status plus data-bit flip enable.
// Shared with the legacy combinational corrector.
module cpc_fec_locator
    import cpc_fec_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0] row_syn_i,
    input  logic [WIDTH-1:0] col_syn_i,
    input  logic             correct_en_i,
    output status_t          status_o,
    output logic             flip_o
);

    onehot_t r_oh;
    onehot_t c_oh;
    logic    r_zero;
    logic    c_zero;

    assign r_oh   = onehot_idx(VEC_W'(row_syn_i));
    assign c_oh   = onehot_idx(VEC_W'(col_syn_i));
    assign r_zero = (row_syn_i == '0);
    assign c_zero = (col_syn_i == '0);

    always_comb begin
        status_o = '0;
        flip_o   = 1'b0;
        if (!(r_zero && c_zero)) begin
            status_o.det = 1'b1;
            if (r_oh.is_onehot && c_oh.is_onehot) begin
                status_o.corr = correct_en_i;
                status_o.row  = r_oh.index;
                status_o.col  = c_oh.index;
                flip_o        = correct_en_i;
            end else if ((r_oh.is_onehot && c_zero) ||
                         (r_zero && c_oh.is_onehot)) begin
                // only a parity bit is wrong; the data is already good
                status_o.corr = correct_en_i;
            end
        end
    end

endmodule

// File: rtl/cpc_fec_stream.sv
// Streaming cross-parity corrector: collect a block, classify, replay
// the corrected rows with per-block status and saturating counters.
module cpc_fec_stream
    import cpc_fec_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     correct_en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_par,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_last,
    output logic                     err_det,
    output logic                     err_corr,
    output logic [$clog2(DEPTH)-1:0] err_row,
    output logic [$clog2(WIDTH)-1:0] err_col,
    output logic                     complete,
    output logic [CNT_W-1:0]         corr_cnt,
    output logic [CNT_W-1:0]         uncorr_cnt
);

    localparam int RW = $clog2(DEPTH);
    localparam int CW = $clog2(WIDTH);
    localparam int BW = $clog2(DEPTH + 1);

    state_e           state_q;
    logic [BW-1:0]    beat_q;
    logic [RW-1:0]    idx_q;
    logic [WIDTH-1:0] buf_q [DEPTH];
    logic [DEPTH-1:0] row_syn_q;
    logic [WIDTH-1:0] col_syn_q;
    logic             ce_q;
    logic             det_q;
    logic             corr_q;
    logic [RW-1:0]    row_q;
    logic [CW-1:0]    col_q;
    logic             cmp_q;
    logic [CNT_W-1:0] cc_q;
    logic [CNT_W-1:0] cc_d;
    logic [CNT_W-1:0] uc_q;
    logic [CNT_W-1:0] uc_d;

    status_t loc_st;
    logic    loc_flip;
    logic    in_fire;
    logic    out_fire;
    logic    last_beat;
    logic    unused_st;

    cpc_fec_locator #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_loc (
        .row_syn_i   (row_syn_q),
        .col_syn_i   (col_syn_q),
        .correct_en_i(ce_q),
        .status_o    (loc_st),
        .flip_o      (loc_flip)
    );

    assign unused_st = ^{loc_st.row, loc_st.col};

    assign in_ready  = (state_q == COLLECT);
    assign in_fire   = in_valid && in_ready;
    assign last_beat = (beat_q == BW'(DEPTH));
    assign out_valid = (state_q == DRAIN);
    assign out_fire  = out_valid && out_ready;
    assign out_data  = buf_q[idx_q];
    assign out_last  = out_valid && (idx_q == RW'(DEPTH - 1));

    always_comb begin
        cc_d = cc_q;
        uc_d = uc_q;
        if (loc_st.corr && (cc_q != '1)) cc_d = cc_q + 1'b1;
        if (loc_st.det && !loc_st.corr && (uc_q != '1)) uc_d = uc_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= COLLECT;
            beat_q    <= '0;
            idx_q     <= '0;
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
            row_syn_q <= '0;
            col_syn_q <= '0;
            ce_q      <= 1'b0;
            det_q     <= 1'b0;
            corr_q    <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            cmp_q     <= 1'b0;
            cc_q      <= '0;
            uc_q      <= '0;
        end else begin
            cmp_q <= 1'b0;
            unique case (state_q)
                COLLECT: begin
                    if (in_fire) begin
                        col_syn_q <= col_syn_q ^ in_data;
                        if (last_beat) begin
                            state_q <= DECIDE;
                        end else begin
                            buf_q[beat_q[RW-1:0]]     <= in_data;
                            row_syn_q[beat_q[RW-1:0]] <= ^in_data ^ in_par;
                            beat_q                    <= beat_q + 1'b1;
                            if (beat_q == '0) ce_q <= correct_en;
                        end
                    end
                end
                DECIDE: begin
                    det_q  <= loc_st.det;
                    corr_q <= loc_st.corr;
                    row_q  <= loc_st.row[RW-1:0];
                    col_q  <= loc_st.col[CW-1:0];
                    if (loc_flip) begin
                        buf_q[loc_st.row[RW-1:0]][loc_st.col[CW-1:0]] <=
                            ~buf_q[loc_st.row[RW-1:0]][loc_st.col[CW-1:0]];
                    end
                    cc_q    <= cc_d;
                    uc_q    <= uc_d;
                    state_q <= DRAIN;
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (out_last) begin
                            idx_q     <= '0;
                            beat_q    <= '0;
                            row_syn_q <= '0;
                            col_syn_q <= '0;
                            det_q     <= 1'b0;
                            corr_q    <= 1'b0;
                            row_q     <= '0;
                            col_q     <= '0;
                            cmp_q     <= 1'b1;
                            state_q   <= COLLECT;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign err_det    = det_q;
    assign err_corr   = corr_q;
    assign err_row    = row_q;
    assign err_col    = col_q;
    assign complete   = cmp_q;
    assign corr_cnt   = cc_q;
    assign uncorr_cnt = uc_q;

endmodule
